ahb_lite_sram_slave: RTL
========================

// Module: ahb_lite_sram_slave
// PURPOSE
// Parametrised AHB-Lite SRAM slave. Word-organised memory with byte-lane writes.
// Programmable wait states. Address-range and alignment checking with the full
// two-cycle AHB ERROR response. Sits behind the AHB-Lite decoder/mux; HSEL comes
// from the decoder and HREADY is the muxed bus ready.
// PARAMETERS
// ADDR_WIDTH   32     width of HADDR
// MEM_WORDS    1024   depth in 32-bit words; power of two, >=4
// BASE_ADDR    0      byte address of word 0; aligned to MEM_WORDS*4
// WAIT_STATES  0      wait cycles inserted per OKAY data phase, 0..7
// PORTS
// HCLK       in   1           bus clock, rising edge
// HRESETn    in   1           asynchronous, active-low reset
// HSEL       in   1           slave select from decoder
// HADDR      in   ADDR_WIDTH  byte address (address phase)
// HTRANS     in   2           00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
// HWRITE     in   1           1 write, 0 read
// HSIZE      in   3           000 byte, 001 half, 010 word; others illegal
// HWDATA     in   32          write data (data phase)
// HREADY     in   1           bus ready; address phase accepted only when 1
// HRDATA     out  32          read data, valid in the completing data-phase cycle
// HREADYOUT  out  1           slave ready / data-phase complete
// HRESP      out  1           0 OKAY, 1 ERROR
// BEHAVIOUR
// Reset: HRDATA=0, HREADYOUT=1, HRESP=0, FSM=IDLE, wait counter=0. Memory is NOT reset.
// Reset asserted mid-transfer aborts the transfer. A pending write is not committed.
// Accept: HSEL & HREADY & HTRANS[1] at a rising edge. Register addr, size, write.
// Same edge: classify error when any of the following hold:
//   (a) HADDR-BASE_ADDR >= MEM_WORDS*4
//   (b) HSIZE>2
//   (c) half access with HADDR[0]=1
//   (d) word access with HADDR[1:0]!=0
// IDLE/BUSY, HSEL=0 or HREADY=0 start no transfer. The next data phase is OKAY,
// zero wait (HREADYOUT=1, HRESP=0).
// FSM states:
//   IDLE: HREADYOUT=1, HRESP=0. Accept+error -> ERR1. Accept+ok -> WAIT_STATES?WAIT:DATA.
//   WAIT: HREADYOUT=0, HRESP=0. Counter loads WAIT_STATES-1 and decrements to 0 -> DATA.
//     Gives exactly WAIT_STATES low cycles.
//   DATA: HREADYOUT=1, HRESP=0. Transfer completes at the edge ending this cycle.
//     Next: same accept rules as IDLE (pipelined back-to-back), else IDLE.
//   ERR1: HREADYOUT=0, HRESP=1 -> ERR2 unconditionally.
//   ERR2: HREADYOUT=1, HRESP=1. Next: accept rules as IDLE.
//     The master may drive IDLE here; the slave must treat it as a normal IDLE.
// Write: HWDATA sampled at the completing edge of the DATA cycle. Only the lanes
// selected by HSIZE/addr[1:0] update:
//   byte lane = addr[1:0]; half lanes = {addr[1],0}+1..0; word = all.
// Errored writes never modify memory.
// Read: HRDATA = mem[word index] during DATA. Full 32-bit word; the master selects lanes.
// HRDATA is held from the last completed read otherwise. Errored reads drive HRDATA=0.
// Word index = (addr-BASE_ADDR)>>2, width $clog2(MEM_WORDS). Address compare uses
// the full ADDR_WIDTH with no wrap-around. An address below BASE_ADDR is out of range.
// Write then read of the same word back-to-back: the read returns the newly written data.
// The write commits at the edge the read address is accepted.
// TESTING
// 1. Reset, WAIT_STATES=0: HREADYOUT=1, HRESP=0, HRDATA=0.
//    Word write 0xA5A5_1234 @0x10 then read @0x10 back-to-back -> 0xA5A5_1234,
//    no wait cycles.
// 2. Byte lanes: word write 0 @0x20; byte 0xEF @0x21; half 0xBEEF @0x22;
//    read @0x20 -> 0xBEEF_EF00.
// 3. WAIT_STATES=3: word read -> HREADYOUT low exactly 3 cycles, then high with
//    valid data. Repeat for a write: memory updates only at completion.
// 4. Out of range: read @ MEM_WORDS*4 -> ERR1 (HREADYOUT=0, HRESP=1), then
//    ERR2 (1,1), HRDATA=0. Write out of range leaves memory intact.
// 5. Misaligned: word write @0x06 and half write @0x03 -> two-cycle ERROR, no
//    memory change. HSIZE=011 -> ERROR.
// 6. Assert HRESETn during WAIT of a write: outputs return to reset values at once;
//    a subsequent read of that word shows the old data.

Source files
------------

// File: rtl/ahb_lite_sram_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_lite_sram_slave_if
// Purpose : AHB-Lite bus bundle between a master (plus decoder/ready mux) and
//           the SRAM slave.
// Signals : HSEL      slave select from the decoder
//           HADDR     byte address (address phase)
//           HTRANS    transfer type: IDLE/BUSY/NONSEQ/SEQ
//           HWRITE    1 write, 0 read
//           HSIZE     transfer size (byte/half/word)
//           HWDATA    write data (data phase)
//           HREADY    muxed bus ready
//           HRDATA    read data from the slave
//           HREADYOUT slave ready / data phase complete
//           HRESP     0 OKAY, 1 ERROR
// ---------------------------------------------------------------------------
interface ahb_lite_sram_slave_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [31:0]           HWDATA;
  logic                  HREADY;
  logic [31:0]           HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;

  // The master side also owns HREADY, since the bus ready mux lives with it.
  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_lite_sram_slave
// Purpose : AHB-Lite SRAM slave. Word-organised memory with byte-lane writes,
//           programmable wait states, and address-range / alignment checking
//           with the two-cycle AHB ERROR response.
// Ports   : HCLK     bus clock, rising edge
//           HRESETn  asynchronous active-low reset
//           bus      ahb_lite_sram_slave_if.slave (HSEL, HADDR, HTRANS,
//                    HWRITE, HSIZE, HWDATA, HREADY in; HRDATA, HREADYOUT,
//                    HRESP out)
// Params  : ADDR_WIDTH, MEM_WORDS (power of two, >=4), BASE_ADDR (aligned to
//           the memory size), WAIT_STATES (0..7)
// ---------------------------------------------------------------------------
module ahb_lite_sram_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    MEM_WORDS   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input logic                  HCLK,
  input logic                  HRESETn,
  ahb_lite_sram_slave_if.slave bus
);

  localparam int                  IDX_W        = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH:0] LP_MEM_BYTES = (ADDR_WIDTH+1)'(MEM_WORDS) << 2;
  localparam logic                LP_HAS_WAIT  = (WAIT_STATES != 0);
  localparam logic [2:0]          LP_WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e                r_state;
  state_e                w_nextState;
  logic [2:0]            r_waitCnt;
  logic [IDX_W-1:0]      r_index;
  logic [1:0]            r_byteOff;
  logic [1:0]            r_size;
  logic                  r_write;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [0:MEM_WORDS-1];

  logic [ADDR_WIDTH-1:0] w_offset;
  logic                  w_outOfRange;
  logic                  w_badSize;
  logic                  w_misaligned;
  logic                  w_err;
  logic                  w_isTransfer;
  logic                  w_canAccept;
  logic                  w_accept;
  logic [3:0]            w_laneEn;
  logic                  w_readyOut;
  logic                  w_resp;
  logic [31:0]           w_rdata;

  // Address-phase decode. Below-base addresses are caught explicitly so the
  // subtraction can never wrap back into range.
  assign w_offset     = bus.HADDR - BASE_ADDR;
  assign w_outOfRange = (bus.HADDR < BASE_ADDR) || ({1'b0, w_offset} >= LP_MEM_BYTES);
  assign w_badSize    = (bus.HSIZE > 3'd2);
  assign w_misaligned = ((bus.HSIZE == 3'd1) && w_offset[0]) ||
                        ((bus.HSIZE == 3'd2) && (w_offset[1:0] != 2'b00));
  assign w_err        = w_outOfRange || w_badSize || w_misaligned;
  assign w_isTransfer = (bus.HTRANS == 2'b10) || (bus.HTRANS == 2'b11);

  // New address phases are only taken in states that drive HREADYOUT high,
  // which is also what makes DATA -> DATA pipelining work.
  assign w_canAccept  = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
  assign w_accept     = w_canAccept && bus.HSEL && bus.HREADY && w_isTransfer;

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (w_accept) begin
          if (w_err) begin
            w_nextState = ST_ERR1;
          end else if (LP_HAS_WAIT) begin
            w_nextState = ST_WAIT;
          end else begin
            w_nextState = ST_DATA;
          end
        end else begin
          w_nextState = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_waitCnt == 3'd0) begin
          w_nextState = ST_DATA;
        end
      end
      ST_ERR1: w_nextState = ST_ERR2;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Handshake outputs as a pure function of state.
  always_comb begin
    w_readyOut = 1'b1;
    w_resp     = 1'b0;
    case (r_state)
      ST_WAIT: w_readyOut = 1'b0;
      ST_ERR1: begin
        w_readyOut = 1'b0;
        w_resp     = 1'b1;
      end
      ST_ERR2: w_resp = 1'b1;
      default: ;
    endcase
  end

  // Read data comes straight from the array during a read data phase so a
  // write committed on the same edge the read was accepted is visible.
  assign w_rdata = ((r_state == ST_DATA) && !r_write) ? r_mem[r_index] : r_rdata;

  assign bus.HREADYOUT = w_readyOut;
  assign bus.HRESP     = w_resp;
  assign bus.HRDATA    = w_rdata;

  // Transfer attributes, wait counter and held read data. An errored read
  // clears the held data; that clear must win over a read completing on the
  // same edge, hence its position after the capture.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_waitCnt <= 3'd0;
      r_index   <= '0;
      r_byteOff <= 2'b00;
      r_size    <= 2'b00;
      r_write   <= 1'b0;
      r_rdata   <= 32'h0;
    end else begin
      if ((r_state == ST_DATA) && !r_write) begin
        r_rdata <= r_mem[r_index];
      end
      if (w_accept) begin
        r_index   <= w_offset[IDX_W+1:2];
        r_byteOff <= w_offset[1:0];
        r_size    <= bus.HSIZE[1:0];
        r_write   <= bus.HWRITE;
        if (w_err && !bus.HWRITE) begin
          r_rdata <= 32'h0;
        end
      end
      if (w_accept && !w_err) begin
        r_waitCnt <= LP_WAIT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_waitCnt != 3'd0)) begin
        r_waitCnt <= r_waitCnt - 3'd1;
      end
    end
  end

  // Byte-lane enables for the committed write.
  always_comb begin
    case (r_size)
      2'd0:    w_laneEn = 4'b0001 << r_byteOff;
      2'd1:    w_laneEn = r_byteOff[1] ? 4'b1100 : 4'b0011;
      default: w_laneEn = 4'b1111;
    endcase
  end

  // Memory array, deliberately not reset. Writes commit at the edge ending
  // the DATA cycle; errored writes never reach DATA.
  always_ff @(posedge HCLK) begin
    if ((r_state == ST_DATA) && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_laneEn[b]) begin
          r_mem[r_index][8*b +: 8] <= bus.HWDATA[8*b +: 8];
        end
      end
    end
  end

endmodule
